pipe_id_issue: RTL and testbench

Instruction-decode and issue stage for the five-stage pipelined MIPS core. Decodes the instruction held in the IF/ID register, selects operands with forwarding from the EX and MEM stages, detects load-use hazards and stalls the front end, and owns the ID/EX pipeline register whose outputs feed the execute stage's `ealuc`, `ealuimm`, `ea`, `eb`, `eimm`, `eshift`, `ern0`, `epc4` and `ejal` inputs. It is the producer side of the ID/EX control encoding.

---
 rtl/pipe_id_issue.sv | 176 +++++++++++++++++
 tb/tb_pipe_id_issue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_id_issue.sv
// pipe_id_issue: instruction-decode and issue stage of the five-stage MIPS core.
//   Decodes the IF/ID instruction, selects rs/rt operands (with EX/MEM
//   forwarding when enabled), detects hazards that require a front-end stall,
//   computes the next-PC source, and owns the ID/EX pipeline register.
// Build option: PIPE_ID_FORWARD_EN
//   defined   - EX/MEM forwarding; stall only on load-use.
//   undefined - operands straight from the register file; stall whenever an
//               EX or MEM writer targets a nonzero register this instruction reads.
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   dinst, dpc4              instruction and its PC+4 from IF/ID
//   qa, qb                   register-file read data (rs, rt)
//   ern/ewreg_fb/em2reg_fb/ealu      EX-stage destination, write, load, result
//   mrn/mwreg/mm2reg/malu/mmo        MEM-stage destination, write, load, results
//   wpcir                    1 = PC and IF/ID may load, 0 = stall
//   pcsource                 00 PC+4, 01 branch, 10 jr, 11 j/jal
//   ealuc..ewmem, ea, eb, eimm, epc4, ern0   ID/EX register outputs
module pipe_id_issue (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dinst,
  input  logic [31:0] dpc4,
  input  logic [31:0] qa,
  input  logic [31:0] qb,
  input  logic [4:0]  ern,
  input  logic        ewreg_fb,
  input  logic        em2reg_fb,
  input  logic [31:0] ealu,
  input  logic [4:0]  mrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic [31:0] malu,
  input  logic [31:0] mmo,
  output logic        wpcir,
  output logic [1:0]  pcsource,
  output logic [3:0]  ealuc,
  output logic        ealuimm,
  output logic        eshift,
  output logic        ejal,
  output logic        ewreg,
  output logic        em2reg,
  output logic        ewmem,
  output logic [31:0] ea,
  output logic [31:0] eb,
  output logic [31:0] eimm,
  output logic [31:0] epc4,
  output logic [4:0]  ern0
);

  logic [5:0] w_op, w_fn;
  logic [4:0] w_rs, w_rt, w_rd;

  assign w_op = dinst[31:26];
  assign w_fn = dinst[5:0];
  assign w_rs = dinst[25:21];
  assign w_rt = dinst[20:16];
  assign w_rd = dinst[15:11];

  logic w_rtype;
  logic w_add, w_sub, w_and, w_or, w_xor, w_sll, w_srl, w_sra, w_jr;
  logic w_addi, w_andi, w_ori, w_xori, w_lw, w_sw, w_beq, w_bne, w_lui, w_j, w_jal;

  assign w_rtype = (w_op == 6'b000000);
  assign w_add   = w_rtype & (w_fn == 6'b100000);
  assign w_sub   = w_rtype & (w_fn == 6'b100010);
  assign w_and   = w_rtype & (w_fn == 6'b100100);
  assign w_or    = w_rtype & (w_fn == 6'b100101);
  assign w_xor   = w_rtype & (w_fn == 6'b100110);
  assign w_sll   = w_rtype & (w_fn == 6'b000000);
  assign w_srl   = w_rtype & (w_fn == 6'b000010);
  assign w_sra   = w_rtype & (w_fn == 6'b000011);
  assign w_jr    = w_rtype & (w_fn == 6'b001000);
  assign w_addi  = (w_op == 6'b001000);
  assign w_andi  = (w_op == 6'b001100);
  assign w_ori   = (w_op == 6'b001101);
  assign w_xori  = (w_op == 6'b001110);
  assign w_lw    = (w_op == 6'b100011);
  assign w_sw    = (w_op == 6'b101011);
  assign w_beq   = (w_op == 6'b000100);
  assign w_bne   = (w_op == 6'b000101);
  assign w_lui   = (w_op == 6'b001111);
  assign w_j     = (w_op == 6'b000010);
  assign w_jal   = (w_op == 6'b000011);

  logic w_shift, w_aluimm, w_wreg, w_zext, w_use_rs, w_use_rt;
  logic [3:0]  w_aluc;
  logic [31:0] w_imm;
  logic [4:0]  w_rn;

  assign w_shift  = w_sll | w_srl | w_sra;
  assign w_aluimm = w_addi | w_andi | w_ori | w_xori | w_lw | w_sw | w_lui;
  assign w_wreg   = w_add | w_sub | w_and | w_or | w_xor | w_shift |
                    w_addi | w_andi | w_ori | w_xori | w_lui | w_lw | w_jal;
  assign w_zext   = w_andi | w_ori | w_xori;
  assign w_imm    = w_zext ? {16'h0000, dinst[15:0]} : {{16{dinst[15]}}, dinst[15:0]};
  assign w_rn     = w_rtype ? w_rd : w_rt;
  // Which register-file sources the instruction actually consumes.
  assign w_use_rs = ~(w_j | w_jal | w_lui);
  assign w_use_rt = w_rtype | w_sw | w_beq | w_bne;

  always_comb begin
    w_aluc = 4'b0000;
    if (w_sub | w_beq | w_bne)  w_aluc = 4'b0100;
    else if (w_and | w_andi)    w_aluc = 4'b0001;
    else if (w_or | w_ori)      w_aluc = 4'b0101;
    else if (w_xor | w_xori)    w_aluc = 4'b0010;
    else if (w_lui)             w_aluc = 4'b0110;
    else if (w_sll)             w_aluc = 4'b0011;
    else if (w_srl)             w_aluc = 4'b0111;
    else if (w_sra)             w_aluc = 4'b1111;
  end

  logic w_e_hit;
  assign w_e_hit = (ern != 5'd0) &
                   ((w_use_rs & (ern == w_rs)) | (w_use_rt & (ern == w_rt)));

  logic [31:0] w_fa, w_fb;
  logic        w_stall;

`ifdef PIPE_ID_FORWARD_EN
  // EX is checked last so it overrides MEM: it holds the younger result.
  always_comb begin
    w_fa = qa;
    if (mwreg && (mrn != 5'd0) && (mrn == w_rs)) w_fa = mm2reg ? mmo : malu;
    if (ewreg_fb && !em2reg_fb && (ern != 5'd0) && (ern == w_rs)) w_fa = ealu;
  end

  always_comb begin
    w_fb = qb;
    if (mwreg && (mrn != 5'd0) && (mrn == w_rt)) w_fb = mm2reg ? mmo : malu;
    if (ewreg_fb && !em2reg_fb && (ern != 5'd0) && (ern == w_rt)) w_fb = ealu;
  end

  // A load in EX has no data yet; wait one cycle so MEM can supply it.
  assign w_stall = ewreg_fb & em2reg_fb & w_e_hit;
`else
  logic w_m_hit;
  logic w_unused;
  assign w_m_hit  = (mrn != 5'd0) &
                    ((w_use_rs & (mrn == w_rs)) | (w_use_rt & (mrn == w_rt)));
  assign w_fa     = qa;
  assign w_fb     = qb;
  // Hold until the producer has reached WB; the register file is write-first.
  assign w_stall  = (ewreg_fb & w_e_hit) | (mwreg & w_m_hit);
  assign w_unused = ^{em2reg_fb, ealu, mm2reg, malu, mmo};
`endif

  assign wpcir = ~w_stall;

  always_comb begin
    pcsource = 2'b00;
    if (!w_stall) begin
      if ((w_beq & (w_fa == w_fb)) | (w_bne & (w_fa != w_fb))) pcsource = 2'b01;
      else if (w_jr)                                           pcsource = 2'b10;
      else if (w_j | w_jal)                                    pcsource = 2'b11;
    end
  end

  // A stall inserts an all-zero bubble, identical to the reset state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ealuc <= 4'd0; ealuimm <= 1'b0; eshift <= 1'b0; ejal <= 1'b0;
      ewreg <= 1'b0; em2reg <= 1'b0; ewmem <= 1'b0;
      ea <= 32'd0; eb <= 32'd0; eimm <= 32'd0; epc4 <= 32'd0; ern0 <= 5'd0;
    end else if (w_stall) begin
      ealuc <= 4'd0; ealuimm <= 1'b0; eshift <= 1'b0; ejal <= 1'b0;
      ewreg <= 1'b0; em2reg <= 1'b0; ewmem <= 1'b0;
      ea <= 32'd0; eb <= 32'd0; eimm <= 32'd0; epc4 <= 32'd0; ern0 <= 5'd0;
    end else begin
      ealuc <= w_aluc; ealuimm <= w_aluimm; eshift <= w_shift; ejal <= w_jal;
      ewreg <= w_wreg; em2reg <= w_lw; ewmem <= w_sw;
      ea <= w_fa; eb <= w_fb; eimm <= w_imm; epc4 <= dpc4; ern0 <= w_rn;
    end
  end

endmodule

// File: tb/tb_pipe_id_issue.sv
module tb_pipe_id_issue;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dinst = '0, dpc4 = '0, qa = '0, qb = '0, ealu = '0, malu = '0, mmo = '0;
  logic [4:0]  ern = '0, mrn = '0;
  logic        ewreg_fb = 1'b0, em2reg_fb = 1'b0, mwreg = 1'b0, mm2reg = 1'b0;

  logic        wpcir, ealuimm, eshift, ejal, ewreg, em2reg, ewmem;
  logic [1:0]  pcsource;
  logic [3:0]  ealuc;
  logic [31:0] ea, eb, eimm, epc4;
  logic [4:0]  ern0;

  pipe_id_issue dut (
    .clock(clock), .reset(reset), .dinst(dinst), .dpc4(dpc4), .qa(qa), .qb(qb),
    .ern(ern), .ewreg_fb(ewreg_fb), .em2reg_fb(em2reg_fb), .ealu(ealu),
    .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .malu(malu), .mmo(mmo),
    .wpcir(wpcir), .pcsource(pcsource), .ealuc(ealuc), .ealuimm(ealuimm),
    .eshift(eshift), .ejal(ejal), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Instruction kinds: 0 unsupported, 1 add 2 sub 3 and 4 or 5 xor 6 sll 7 srl
  // 8 sra 9 jr 10 addi 11 andi 12 ori 13 xori 14 lw 15 sw 16 beq 17 bne 18 lui
  // 19 j 20 jal
  bit [5:0] T_OP   [0:20] = '{6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,
                              6'h08,6'h0C,6'h0D,6'h0E,6'h23,6'h2B,6'h04,6'h05,6'h0F,6'h02,6'h03};
  bit [5:0] T_FN   [0:20] = '{6'h3F,6'h20,6'h22,6'h24,6'h25,6'h26,6'h00,6'h02,6'h03,6'h08,
                              6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00};
  bit [3:0] T_ALUC [0:20] = '{4'd0,4'd0,4'd4,4'd1,4'd5,4'd2,4'd3,4'd7,4'd15,4'd0,
                              4'd0,4'd1,4'd5,4'd2,4'd0,4'd0,4'd4,4'd4,4'd6,4'd0,4'd0};
  bit T_IMM  [0:20] = '{0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,0,0,1,0,0};
  bit T_SH   [0:20] = '{0,0,0,0,0,0,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0};
  bit T_WREG [0:20] = '{0,1,1,1,1,1,1,1,1,0,1,1,1,1,1,0,0,0,1,0,1};
  bit T_ZX   [0:20] = '{0,0,0,0,0,0,0,0,0,0,0,1,1,1,0,0,0,0,0,0,0};

  logic        exp_wpcir;
  logic [1:0]  exp_pcs;
  logic [3:0]  nx_aluc, ex_aluc;
  logic        nx_aluimm, nx_shift, nx_jal, nx_wreg, nx_m2reg, nx_wmem;
  logic        ex_aluimm, ex_shift, ex_jal, ex_wreg, ex_m2reg, ex_wmem;
  logic [31:0] nx_a, nx_b, nx_imm, nx_pc4, ex_a, ex_b, ex_imm, ex_pc4;
  logic [4:0]  nx_rn, ex_rn;

  function automatic int kind_of(logic [31:0] ins);
    for (int k = 1; k <= 20; k++)
      if (ins[31:26] == T_OP[k] && (ins[31:26] != 6'd0 || ins[5:0] == T_FN[k])) return k;
    return 0;
  endfunction

  function automatic logic [31:0] fwd(logic [4:0] r, logic [31:0] q);
    if (r != 0 && ewreg_fb && !em2reg_fb && ern == r) return ealu;
    if (r != 0 && mwreg && mrn == r) return mm2reg ? mmo : malu;
    return q;
  endfunction

  function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                       logic [4:0] rd, logic [4:0] sh);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                       logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic model();
    int k;
    logic [4:0] rs, rt, rd;
    logic urs, urt, hit_e, hit_m, stall;
    logic [31:0] a, b;
    k  = kind_of(dinst);
    rs = dinst[25:21]; rt = dinst[20:16]; rd = dinst[15:11];
    urs = !(k == 18 || k == 19 || k == 20);
    urt = (dinst[31:26] == 6'd0) || k == 15 || k == 16 || k == 17;
    hit_e = ern != 0 && ((urs && ern == rs) || (urt && ern == rt));
    hit_m = mrn != 0 && ((urs && mrn == rs) || (urt && mrn == rt));
`ifdef PIPE_ID_FORWARD_EN
    stall = ewreg_fb && em2reg_fb && hit_e;
    a = fwd(rs, qa); b = fwd(rt, qb);
`else
    stall = (ewreg_fb && hit_e) || (mwreg && hit_m);
    a = qa; b = qb;
`endif
    exp_wpcir = !stall;
    if (stall)                                              exp_pcs = 2'b00;
    else if ((k == 16 && a == b) || (k == 17 && a != b))   exp_pcs = 2'b01;
    else if (k == 9)                                        exp_pcs = 2'b10;
    else if (k == 19 || k == 20)                            exp_pcs = 2'b11;
    else                                                    exp_pcs = 2'b00;
    if (stall) begin
      nx_aluc = 0; nx_aluimm = 0; nx_shift = 0; nx_jal = 0; nx_wreg = 0; nx_m2reg = 0;
      nx_wmem = 0; nx_a = 0; nx_b = 0; nx_imm = 0; nx_pc4 = 0; nx_rn = 0;
    end else begin
      nx_aluc = T_ALUC[k]; nx_aluimm = T_IMM[k]; nx_shift = T_SH[k]; nx_jal = (k == 20);
      nx_wreg = T_WREG[k]; nx_m2reg = (k == 14); nx_wmem = (k == 15);
      nx_a = a; nx_b = b; nx_pc4 = dpc4;
      nx_imm = T_ZX[k] ? {16'h0, dinst[15:0]} : {{16{dinst[15]}}, dinst[15:0]};
      nx_rn = (dinst[31:26] == 6'd0) ? rd : rt;
    end
  endtask

  task automatic clear_exp();
    ex_aluc = 0; ex_aluimm = 0; ex_shift = 0; ex_jal = 0; ex_wreg = 0; ex_m2reg = 0;
    ex_wmem = 0; ex_a = 0; ex_b = 0; ex_imm = 0; ex_pc4 = 0; ex_rn = 0;
  endtask

  task automatic check_e(string tag);
    chk({tag, "_ealuc"}, 32'(ealuc), 32'(ex_aluc));
    chk({tag, "_ealuimm"}, 32'(ealuimm), 32'(ex_aluimm));
    chk({tag, "_eshift"}, 32'(eshift), 32'(ex_shift));
    chk({tag, "_ejal"}, 32'(ejal), 32'(ex_jal));
    chk({tag, "_ewreg"}, 32'(ewreg), 32'(ex_wreg));
    chk({tag, "_em2reg"}, 32'(em2reg), 32'(ex_m2reg));
    chk({tag, "_ewmem"}, 32'(ewmem), 32'(ex_wmem));
    chk({tag, "_ea"}, ea, ex_a);
    chk({tag, "_eb"}, eb, ex_b);
    chk({tag, "_eimm"}, eimm, ex_imm);
    chk({tag, "_epc4"}, epc4, ex_pc4);
    chk({tag, "_ern0"}, 32'(ern0), 32'(ex_rn));
  endtask

  // Inputs are driven at the falling edge; combinational outputs checked 1ns later.
  task automatic settle(string tag);
    #1;
    model();
    chk({tag, "_wpcir"}, 32'(wpcir), 32'(exp_wpcir));
    chk({tag, "_pcsource"}, 32'(pcsource), 32'(exp_pcs));
  endtask

  task automatic clk_e(string tag);
    @(posedge clock);
    #1;
    ex_aluc = nx_aluc; ex_aluimm = nx_aluimm; ex_shift = nx_shift; ex_jal = nx_jal;
    ex_wreg = nx_wreg; ex_m2reg = nx_m2reg; ex_wmem = nx_wmem; ex_a = nx_a; ex_b = nx_b;
    ex_imm = nx_imm; ex_pc4 = nx_pc4; ex_rn = nx_rn;
    check_e(tag);
    @(negedge clock);
  endtask

  task automatic set_idle();
    ern = 0; ewreg_fb = 0; em2reg_fb = 0; mrn = 0; mwreg = 0; mm2reg = 0;
  endtask

  task automatic pulse_reset(string tag);
    #1 reset = 1'b1;
    #1;
    clear_exp();
    check_e(tag);
    @(posedge clock);
    #1;
    check_e({tag, "_hold"});
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int k;
    logic [31:0] v;
    logic [15:0] im;
    logic [25:0] tg;
    clear_exp();
    repeat (2) @(negedge clock);
    check_e("rst");
    settle("rst");
    reset = 1'b0;

    // Load something non-zero, then reset mid-cycle with a valid dinst present.
    dinst = enc_r(6'h20, 5'd3, 5'd3, 5'd4, 5'd0); qa = 32'h55; qb = 32'h55; dpc4 = 32'h40;
    settle("pre"); clk_e("pre");
    chk("pre_ea_lit", ea, 32'h55);
    #2 reset = 1'b1;
    #1;
    clear_exp();
    check_e("midrst");
    chk("midrst_ea_lit", ea, 32'h0);
    @(posedge clock); @(negedge clock);
    reset = 1'b0;

    dinst = enc_i(6'h08, 5'd0, 5'd1, 16'd5); qa = 0; qb = 0;
    settle("addi"); clk_e("addi");
    chk("addi_ealuc_lit", 32'(ealuc), 32'h0);
    chk("addi_ealuimm_lit", 32'(ealuimm), 32'h1);
    chk("addi_eimm_lit", eimm, 32'd5);
    chk("addi_ern0_lit", 32'(ern0), 32'd1);
    chk("addi_ewreg_lit", 32'(ewreg), 32'd1);

    dinst = enc_i(6'h0C, 5'd1, 5'd2, 16'h8000);
    settle("andi"); clk_e("andi");
    chk("andi_eimm_lit", eimm, 32'h0000_8000);
    dinst = enc_i(6'h08, 5'd1, 5'd2, 16'h8000);
    settle("addi8k"); clk_e("addi8k");
    chk("addi8k_eimm_lit", eimm, 32'hFFFF_8000);

    ern = 3; ewreg_fb = 1; em2reg_fb = 0; ealu = 7; mrn = 3; mwreg = 1; mm2reg = 0; malu = 9;
    qa = 1; qb = 1; dinst = enc_r(6'h20, 5'd3, 5'd3, 5'd4, 5'd0);
    settle("fwd");
`ifdef PIPE_ID_FORWARD_EN
    chk("fwd_wpcir_lit", 32'(wpcir), 32'd1);
    clk_e("fwd");
    chk("fwd_ea_lit", ea, 32'd7);
    chk("fwd_eb_lit", eb, 32'd7);
`else
    chk("fwd_wpcir_lit", 32'(wpcir), 32'd0);
    clk_e("fwd");
    chk("fwd_bubble_lit", 32'(ewreg), 32'd0);
`endif

    set_idle();
    ern = 5; ewreg_fb = 1; em2reg_fb = 1; qa = 32'hDEAD; qb = 2;
    dinst = enc_r(6'h22, 5'd5, 5'd2, 5'd6, 5'd0);
    settle("luse");
    chk("luse_wpcir_lit", 32'(wpcir), 32'd0);
    clk_e("luse");
    chk("luse_ewreg_lit", 32'(ewreg), 32'd0);
    ern = 0; ewreg_fb = 0; em2reg_fb = 0; mrn = 5; mwreg = 1; mm2reg = 1;
    mmo = 32'h1234; malu = 32'h9999;
`ifdef PIPE_ID_FORWARD_EN
    settle("luse2");
    chk("luse2_wpcir_lit", 32'(wpcir), 32'd1);
    clk_e("luse2");
`else
    settle("luse2");
    chk("luse2_wpcir_lit", 32'(wpcir), 32'd0);
    clk_e("luse2");
    mwreg = 0; mrn = 0; qa = 32'h1234;
    settle("luse3"); clk_e("luse3");
`endif
    chk("luse_ea_lit", ea, 32'h1234);

    set_idle();
    dinst = {6'h03, 26'h0000_040}; dpc4 = 32'h104;
    settle("jal");
    chk("jal_pcs_lit", 32'(pcsource), 32'd3);
    clk_e("jal");
    chk("jal_ejal_lit", 32'(ejal), 32'd1);
    chk("jal_epc4_lit", epc4, 32'h104);
    chk("jal_ewreg_lit", 32'(ewreg), 32'd1);

    dinst = enc_i(6'h04, 5'd1, 5'd2, 16'h0010);
`ifdef PIPE_ID_FORWARD_EN
    ern = 1; ewreg_fb = 1; ealu = 32'hA; mrn = 2; mwreg = 1; malu = 32'hA; qa = 0; qb = 5;
`else
    qa = 32'hA; qb = 32'hA;
`endif
    settle("beq_eq");
    chk("beq_eq_pcs_lit", 32'(pcsource), 32'd1);
    clk_e("beq_eq");
`ifdef PIPE_ID_FORWARD_EN
    malu = 32'hB;
`else
    qb = 32'hB;
`endif
    settle("beq_ne");
    chk("beq_ne_pcs_lit", 32'(pcsource), 32'd0);
    clk_e("beq_ne");

    set_idle();
    dinst = enc_r(6'h00, 5'd0, 5'd2, 5'd3, 5'd4);
    settle("sll"); clk_e("sll");
    chk("sll_eshift_lit", 32'(eshift), 32'd1);
    chk("sll_shamt_lit", 32'(eimm[10:6]), 32'd4);
    chk("sll_ealuc_lit", 32'(ealuc), 32'h3);

    for (int it = 0; it < 800; it++) begin
      k = $urandom_range(1, 20);
      im = 16'($urandom);
      tg = 26'($urandom);
      if (T_OP[k] == 6'd0)
        dinst = enc_r(T_FN[k], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      else if (k == 19 || k == 20)
        dinst = {T_OP[k], tg};
      else
        dinst = enc_i(T_OP[k], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), im);
      dpc4 = $urandom;
      ern = 5'($urandom_range(0, 7)); mrn = 5'($urandom_range(0, 7));
      ewreg_fb = 1'($urandom); em2reg_fb = 1'($urandom);
      mwreg = 1'($urandom); mm2reg = 1'($urandom);
      v = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        qa = v; qb = v; ealu = v; malu = v; mmo = v;
      end else begin
        qa = $urandom; qb = $urandom; ealu = $urandom; malu = $urandom; mmo = $urandom;
      end
      settle("rnd");
      if ($urandom_range(0, 49) == 0) pulse_reset("rnd_rst");
      else clk_e("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
